// File: rtl/aos_pkg.sv
// Shared definitions for the AOS stream feeder.
//   - register byte offsets of the bus-facing register map
//   - CTRL / STATUS bit positions
//   - feeder FSM state encoding
//   - FIFO entry layout (end-of-frame flag + pixel word)
package aos_pkg;

  localparam int AOS_DATA_W = 32;

  // Register byte offsets
  localparam int unsigned AOS_FEED_DATA     = 32'h0;
  localparam int unsigned AOS_FEED_CTRL     = 32'h4;
  localparam int unsigned AOS_FEED_STATUS   = 32'h8;
  localparam int unsigned AOS_FEED_DATA_EOF = 32'hC;

  // CTRL bits above the frame_width field
  localparam int CTRL_EN_BIT  = 16;
  localparam int CTRL_CLR_BIT = 17;

  // STATUS bits
  localparam int STAT_FULL_BIT   = 8;
  localparam int STAT_EMPTY_BIT  = 9;
  localparam int STAT_FRAMES_LSB = 16;

  typedef enum logic [1:0] {
    FEED_IDLE  = 2'd0,
    FEED_RUN   = 2'd1,
    FEED_FLUSH = 2'd2
  } feed_state_e;

  typedef struct packed {
    logic                  eof;
    logic [AOS_DATA_W-1:0] data;
  } feed_entry_t;

endpackage

// File: rtl/aos_sync_fifo.sv
// Single-clock show-ahead FIFO.
//   clk, rst : clock and synchronous active-high reset
//   push/din : write an entry (taken when not full, or when full with a
//              simultaneous pop)
//   pop      : consume the head entry; dout always shows the head
//   flush    : empty the FIFO in one cycle (wins over push/pop)
//   full, empty, count : occupancy
module aos_sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A push while full is only legal when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/aos_strm_feeder.sv
// Upstream feeder for the AOS AXI4-stream core.
// Bus writes to DATA / DATA_EOF are queued in a FIFO and emitted as AXIS
// beats through a single output register stage. TLAST closes a frame every
// frame_width beats, or on a DATA_EOF entry.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   bus_req_* / bus_rsp_*    register bus (valid/ready request, 1-cycle read data)
//   strm_out_*               AXIS master (data, valid, ready, keep, last)
//   dbg_state_o              current FSM state (feed_state_e encoding)
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; a valid source holds its payload until that edge and never
// withdraws valid beforehand.
module aos_strm_feeder
  import aos_pkg::*;
#(
  parameter int DATA_W = AOS_DATA_W,  // must match AOS_DATA_W (entry layout)
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  parameter int FWID_W = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bus_req_valid,
  input  logic                bus_req_write,
  input  logic [ADDR_W-1:0]   bus_req_addr,
  input  logic [DATA_W-1:0]   bus_req_wdata,
  output logic                bus_req_ready,
  output logic                bus_rsp_valid,
  output logic [DATA_W-1:0]   bus_rsp_rdata,
  output logic [DATA_W-1:0]   strm_out_data,
  output logic                strm_out_valid,
  input  logic                strm_out_ready,
  output logic [DATA_W/8-1:0] strm_out_keep,
  output logic                strm_out_last,
  output logic [1:0]          dbg_state_o
);

  localparam int CNT_W = $clog2(DEPTH+1);

  // Registers
  feed_state_e       state_q, state_d;
  logic [FWID_W-1:0] fw_q, fw_d;
  logic              en_q, en_d;
  logic [FWID_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [15:0]       frames_q, frames_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  // Decode / control
  logic sel_data, sel_ctrl, sel_status, sel_eof;
  logic is_push_wr, accept, fifo_push, ctrl_wr, clear_wr, rd_acc;
  logic hs, load, flush_step;
  logic [DATA_W-1:0] rd_mux;
  logic [FWID_W-1:0] fw_eff, cnt_base;
  logic              load_last;

  // FIFO
  feed_entry_t      push_entry, head;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  assign sel_data   = (bus_req_addr == ADDR_W'(AOS_FEED_DATA));
  assign sel_ctrl   = (bus_req_addr == ADDR_W'(AOS_FEED_CTRL));
  assign sel_status = (bus_req_addr == ADDR_W'(AOS_FEED_STATUS));
  assign sel_eof    = (bus_req_addr == ADDR_W'(AOS_FEED_DATA_EOF));

  assign is_push_wr = bus_req_valid && bus_req_write && (sel_data || sel_eof);

  // Output stage: load from the FIFO head when the stage is free or its beat
  // completes now. Loading pops the FIFO, which also frees a slot for a
  // same-cycle push when the FIFO is full.
  assign hs   = out_valid_q && strm_out_ready;
  assign load = (state_q == FEED_RUN) && en_q && !fifo_empty && (!out_valid_q || hs);

  assign bus_req_ready = (state_q != FEED_FLUSH) && !(is_push_wr && fifo_full && !load);

  assign accept    = bus_req_valid && bus_req_ready;
  assign fifo_push = accept && bus_req_write && (sel_data || sel_eof);
  assign ctrl_wr   = accept && bus_req_write && sel_ctrl;
  assign clear_wr  = ctrl_wr && bus_req_wdata[CTRL_CLR_BIT];
  assign rd_acc    = accept && !bus_req_write;

  assign push_entry.eof  = sel_eof;
  assign push_entry.data = bus_req_wdata;

  aos_sync_fifo #(
    .WIDTH($bits(feed_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .pop  (load),
    .flush(flush_step),
    .din  (push_entry),
    .dout (head),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  // A width of 0 behaves as 1 so every beat closes a frame.
  assign fw_eff = (fw_q == '0) ? FWID_W'(1) : fw_q;

  // Position of the beat being loaded: beats completed so far, including
  // one that completes in this very cycle.
  assign cnt_base = hs ? (out_last_q ? '0 : beat_cnt_q + FWID_W'(1)) : beat_cnt_q;

  // ">=" so that shrinking frame_width mid-frame closes the frame at once.
  assign load_last = head.eof || (cnt_base >= fw_eff - FWID_W'(1));

  // FSM next state
  always_comb begin
    state_d    = state_q;
    flush_step = 1'b0;
    case (state_q)
      FEED_IDLE: if (en_q) state_d = FEED_RUN;
      FEED_RUN:  if (!en_q && !out_valid_q) state_d = FEED_IDLE;
      FEED_FLUSH: begin
        // Let the held beat drain first, then drop everything queued.
        if (!out_valid_q) begin
          flush_step = 1'b1;
          state_d    = en_q ? FEED_RUN : FEED_IDLE;
        end
      end
      default: state_d = FEED_IDLE;
    endcase
    if (clear_wr) state_d = FEED_FLUSH;
  end

  // Read mux
  always_comb begin
    rd_mux = '0;
    if (sel_ctrl) begin
      rd_mux[FWID_W-1:0]  = fw_q;
      rd_mux[CTRL_EN_BIT] = en_q;
    end else if (sel_status) begin
      rd_mux[4:0]                            = 5'(fifo_count);
      rd_mux[STAT_FULL_BIT]                  = fifo_full;
      rd_mux[STAT_EMPTY_BIT]                 = fifo_empty;
      rd_mux[STAT_FRAMES_LSB+15:STAT_FRAMES_LSB] = frames_q;
    end
  end

  // Datapath next state
  always_comb begin
    fw_d        = fw_q;
    en_d        = en_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    frames_d    = frames_q;
    beat_cnt_d  = flush_step ? '0 : cnt_base;
    rsp_valid_d = rd_acc;
    rsp_rdata_d = rd_acc ? rd_mux : rsp_rdata_q;

    if (ctrl_wr) begin
      fw_d = bus_req_wdata[FWID_W-1:0];
      en_d = bus_req_wdata[CTRL_EN_BIT];
    end

    if (hs && out_last_q) frames_d = frames_q + 16'd1;

    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = head.data;
      out_last_d  = load_last;
    end else if (hs) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FEED_IDLE;
      fw_q        <= FWID_W'(128);
      en_q        <= 1'b0;
      beat_cnt_q  <= '0;
      frames_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      fw_q        <= fw_d;
      en_q        <= en_d;
      beat_cnt_q  <= beat_cnt_d;
      frames_q    <= frames_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign strm_out_valid = out_valid_q;
  assign strm_out_data  = out_data_q;
  assign strm_out_last  = out_last_q;
  assign strm_out_keep  = '1;
  assign bus_rsp_valid  = rsp_valid_q;
  assign bus_rsp_rdata  = rsp_rdata_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_aos_strm_feeder.sv
module tb_aos_strm_feeder;

  localparam logic [3:0] A_DATA   = 4'h0;
  localparam logic [3:0] A_CTRL   = 4'h4;
  localparam logic [3:0] A_STATUS = 4'h8;
  localparam logic [3:0] A_EOF    = 4'hC;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_req_valid, bus_req_write;
  logic [3:0]  bus_req_addr;
  logic [31:0] bus_req_wdata;
  logic        bus_req_ready, bus_rsp_valid;
  logic [31:0] bus_rsp_rdata;
  logic [31:0] strm_out_data;
  logic        strm_out_valid, strm_out_ready, strm_out_last;
  logic [3:0]  strm_out_keep;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // Scoreboard of completed output beats
  logic [31:0] got_data[$];
  logic        got_last[$];

  logic        stall_q;
  logic [31:0] stall_data;
  logic        stall_last;

  aos_strm_feeder dut (
    .clk           (clk),
    .rst           (rst),
    .bus_req_valid (bus_req_valid),
    .bus_req_write (bus_req_write),
    .bus_req_addr  (bus_req_addr),
    .bus_req_wdata (bus_req_wdata),
    .bus_req_ready (bus_req_ready),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rsp_rdata (bus_rsp_rdata),
    .strm_out_data (strm_out_data),
    .strm_out_valid(strm_out_valid),
    .strm_out_ready(strm_out_ready),
    .strm_out_keep (strm_out_keep),
    .strm_out_last (strm_out_last),
    .dbg_state_o   (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- output monitor ----------------
  // Records every handshake; a stalled beat must reappear unchanged.
  always @(negedge clk) begin
    if (rst) begin
      stall_q <= 1'b0;
    end else begin
      if (stall_q) begin
        checks++;
        if (!(strm_out_valid === 1'b1 && strm_out_data === stall_data && strm_out_last === stall_last)) begin
          errors++;
          $display("FAIL stall_hold got v=%0b d=%h l=%0b exp v=1 d=%h l=%0b",
                   strm_out_valid, strm_out_data, strm_out_last, stall_data, stall_last);
        end
      end
      if (strm_out_valid && strm_out_ready) begin
        got_data.push_back(strm_out_data);
        got_last.push_back(strm_out_last);
      end
      stall_q    <= strm_out_valid && !strm_out_ready;
      stall_data <= strm_out_data;
      stall_last <= strm_out_last;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    int n;
    n = 0;
    bus_req_valid = 1'b1;
    bus_req_write = 1'b1;
    bus_req_addr  = a;
    bus_req_wdata = d;
    @(negedge clk);
    while (!bus_req_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL bus_write_timeout addr=%h got ready=0 exp ready=1", a);
    end
    @(posedge clk); #1;
    bus_req_valid = 1'b0;
    bus_req_write = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    int n;
    n = 0;
    bus_req_valid = 1'b1;
    bus_req_write = 1'b0;
    bus_req_addr  = a;
    bus_req_wdata = '0;
    @(negedge clk);
    while (!bus_req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL bus_read_timeout addr=%h got ready=0 exp ready=1", a);
    end
    @(posedge clk); #1;
    bus_req_valid = 1'b0;
    @(negedge clk);
    d = bus_rsp_valid ? bus_rsp_rdata : 32'hDEAD_BEEF;
    @(posedge clk); #1;
  endtask

  task automatic wait_beats(input int n);
    int c;
    c = 0;
    while (got_data.size() < n && c < 8000) begin
      @(posedge clk); #1;
      c++;
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] r;
    @(negedge clk);
    checks++;
    if (strm_out_valid !== 1'b0 || strm_out_last !== 1'b0 || strm_out_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_stream got v=%0b l=%0b d=%h exp 0 0 0", strm_out_valid, strm_out_last, strm_out_data);
    end
    checks++;
    if (bus_req_ready !== 1'b1 || bus_rsp_valid !== 1'b0 || bus_rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus got rdy=%0b rv=%0b rd=%h exp 1 0 0", bus_req_ready, bus_rsp_valid, bus_rsp_rdata);
    end
    checks++;
    if (dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL reset_state got %0d exp %0d", dbg_state, S_IDLE);
    end
    @(posedge clk); #1;
    bus_read(A_STATUS, r);
    checks++;
    if (r !== 32'h0000_0200) begin errors++; $display("FAIL reset_status got %h exp 00000200", r); end
    bus_read(A_CTRL, r);
    checks++;
    if (r !== 32'h0000_0080) begin errors++; $display("FAIL reset_ctrl got %h exp 00000080", r); end
  endtask

  task automatic test_latency();
    strm_out_ready = 1'b1;
    got_data.delete(); got_last.delete();
    bus_write(A_CTRL, 32'h0001_0001);
    bus_write(A_DATA, 32'h0000_0055);
    @(negedge clk);
    checks++;
    if (strm_out_valid !== 1'b0) begin errors++; $display("FAIL latency_cycle1 got v=%0b exp v=0", strm_out_valid); end
    @(negedge clk);
    checks++;
    if (strm_out_valid !== 1'b1 || strm_out_data !== 32'h55 || strm_out_last !== 1'b1) begin
      errors++;
      $display("FAIL latency_cycle2 got v=%0b d=%h l=%0b exp 1 00000055 1", strm_out_valid, strm_out_data, strm_out_last);
    end
    checks++;
    if (strm_out_keep !== 4'hF) begin errors++; $display("FAIL keep got %h exp f", strm_out_keep); end
    @(posedge clk); #1;
    wait_beats(1);
  endtask

  task automatic test_framing();
    logic [31:0] r;
    got_data.delete(); got_last.delete();
    bus_write(A_CTRL, 32'h0001_0004);
    for (int i = 0; i < 8; i++) bus_write(A_DATA, 32'(i));
    wait_beats(8);
    checks++;
    if (got_data.size() != 8) begin errors++; $display("FAIL framing_count got %0d exp 8", got_data.size()); end
    for (int i = 0; i < 8 && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== 32'(i) || got_last[i] !== ((i % 4) == 3)) begin
        errors++;
        $display("FAIL framing_beat%0d got d=%h l=%0b exp d=%h l=%0b", i, got_data[i], got_last[i], 32'(i), (i % 4) == 3);
      end
    end
    bus_read(A_STATUS, r);
    checks++;
    if (r !== 32'h0003_0200) begin errors++; $display("FAIL framing_status got %h exp 00030200", r); end
  endtask

  task automatic test_eof();
    logic [31:0] r;
    logic [31:0] exp_d[6];
    logic        exp_l[6];
    exp_d = '{32'h10, 32'h11, 32'h12, 32'hAB, 32'h20, 32'h21};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    got_data.delete(); got_last.delete();
    bus_write(A_CTRL, 32'h0001_0080);
    bus_write(A_DATA, 32'h10);
    bus_write(A_DATA, 32'h11);
    bus_write(A_DATA, 32'h12);
    bus_write(A_EOF,  32'hAB);
    wait_beats(4);
    // A fresh 2-beat frame only closes on its 2nd beat if beat_cnt restarted at 0.
    bus_write(A_CTRL, 32'h0001_0002);
    bus_write(A_DATA, 32'h20);
    bus_write(A_DATA, 32'h21);
    wait_beats(6);
    checks++;
    if (got_data.size() != 6) begin errors++; $display("FAIL eof_count got %0d exp 6", got_data.size()); end
    for (int i = 0; i < 6 && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_d[i] || got_last[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL eof_beat%0d got d=%h l=%0b exp d=%h l=%0b", i, got_data[i], got_last[i], exp_d[i], exp_l[i]);
      end
    end
    bus_read(A_STATUS, r);
    checks++;
    if (r !== 32'h0005_0200) begin errors++; $display("FAIL eof_status got %h exp 00050200", r); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    strm_out_ready = 1'b0;
    got_data.delete(); got_last.delete();
    bus_write(A_CTRL, 32'h0001_0080);
    for (int i = 0; i < 17; i++) bus_write(A_DATA, 32'h100 + 32'(i));
    idle_cycles(2);
    bus_read(A_STATUS, r);
    checks++;
    if (r !== 32'h0005_0110) begin errors++; $display("FAIL bp_status_full got %h exp 00050110", r); end
    checks++;
    if (strm_out_valid !== 1'b1 || strm_out_data !== 32'h100) begin
      errors++;
      $display("FAIL bp_held got v=%0b d=%h exp 1 00000100", strm_out_valid, strm_out_data);
    end
    // 18th write must stall until the held beat leaves
    bus_req_valid = 1'b1;
    bus_req_write = 1'b1;
    bus_req_addr  = A_DATA;
    bus_req_wdata = 32'h111;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (bus_req_ready !== 1'b0) begin errors++; $display("FAIL bp_stall%0d got ready=%0b exp 0", k, bus_req_ready); end
    end
    @(posedge clk); #1;
    strm_out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_req_ready !== 1'b1) begin errors++; $display("FAIL bp_release got ready=%0b exp 1", bus_req_ready); end
    @(posedge clk); #1;
    bus_req_valid = 1'b0;
    bus_req_write = 1'b0;
    wait_beats(18);
    checks++;
    if (got_data.size() != 18) begin errors++; $display("FAIL bp_count got %0d exp 18", got_data.size()); end
    for (int i = 0; i < 18 && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== 32'h100 + 32'(i) || got_last[i] !== 1'b0) begin
        errors++;
        $display("FAIL bp_beat%0d got d=%h l=%0b exp d=%h l=0", i, got_data[i], got_last[i], 32'h100 + 32'(i));
      end
    end
  endtask

  task automatic test_random_ready();
    logic [31:0] r;
    pulse_reset();
    got_data.delete(); got_last.delete();
    bus_write(A_CTRL, 32'h0001_0064);
    fork
      begin
        for (int i = 0; i < 300; i++) bus_write(A_DATA, 32'(i * 7 + 3));
      end
      begin
        int c;
        c = 0;
        while (got_data.size() < 300 && c < 8000) begin
          @(posedge clk); #1;
          strm_out_ready = 1'($urandom_range(0, 1));
          c++;
        end
        strm_out_ready = 1'b1;
      end
    join
    wait_beats(300);
    checks++;
    if (got_data.size() != 300) begin errors++; $display("FAIL rand_count got %0d exp 300", got_data.size()); end
    for (int i = 0; i < 300 && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== 32'(i * 7 + 3) || got_last[i] !== ((i % 100) == 99)) begin
        errors++;
        $display("FAIL rand_beat%0d got d=%h l=%0b exp d=%h l=%0b", i, got_data[i], got_last[i], 32'(i * 7 + 3), (i % 100) == 99);
      end
    end
    bus_read(A_STATUS, r);
    checks++;
    if (r !== 32'h0003_0200) begin errors++; $display("FAIL rand_status got %h exp 00030200", r); end
  endtask

  task automatic test_fw_zero();
    logic [31:0] r;
    strm_out_ready = 1'b1;
    got_data.delete(); got_last.delete();
    bus_write(A_CTRL, 32'h0001_0000);
    for (int i = 0; i < 3; i++) bus_write(A_DATA, 32'h40 + 32'(i));
    wait_beats(3);
    checks++;
    if (got_data.size() != 3) begin errors++; $display("FAIL fw0_count got %0d exp 3", got_data.size()); end
    for (int i = 0; i < 3 && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== 32'h40 + 32'(i) || got_last[i] !== 1'b1) begin
        errors++;
        $display("FAIL fw0_beat%0d got d=%h l=%0b exp d=%h l=1", i, got_data[i], got_last[i], 32'h40 + 32'(i));
      end
    end
    bus_read(A_STATUS, r);
    checks++;
    if (r !== 32'h0006_0200) begin errors++; $display("FAIL fw0_status got %h exp 00060200", r); end
  endtask

  task automatic test_clear();
    logic [31:0] r;
    logic [31:0] exp_d[5];
    logic        exp_l[5];
    exp_d = '{32'h200, 32'h201, 32'h202, 32'h300, 32'h301};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    strm_out_ready = 1'b1;
    got_data.delete(); got_last.delete();
    bus_write(A_CTRL, 32'h0001_0080);
    bus_write(A_DATA, 32'h200);
    bus_write(A_DATA, 32'h201);
    wait_beats(2);
    strm_out_ready = 1'b0;
    for (int i = 2; i < 8; i++) bus_write(A_DATA, 32'h200 + 32'(i));
    idle_cycles(3);
    bus_read(A_STATUS, r);
    checks++;
    if (r !== 32'h0006_0005) begin errors++; $display("FAIL clr_pre_status got %h exp 00060005", r); end
    bus_write(A_CTRL, 32'h0003_0080);
    @(negedge clk);
    checks++;
    if (dbg_state !== S_FLUSH || bus_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL clr_flush got st=%0d rdy=%0b exp st=%0d rdy=0", dbg_state, bus_req_ready, S_FLUSH);
    end
    @(posedge clk); #1;
    strm_out_ready = 1'b1;
    idle_cycles(6);
    checks++;
    if (got_data.size() != 3) begin errors++; $display("FAIL clr_drain_count got %0d exp 3", got_data.size()); end
    checks++;
    if (dbg_state !== S_RUN) begin errors++; $display("FAIL clr_state got %0d exp %0d", dbg_state, S_RUN); end
    bus_read(A_STATUS, r);
    checks++;
    if (r !== 32'h0006_0200) begin errors++; $display("FAIL clr_post_status got %h exp 00060200", r); end
    bus_read(A_CTRL, r);
    checks++;
    if (r !== 32'h0001_0080) begin errors++; $display("FAIL clr_ctrl got %h exp 00010080", r); end
    bus_write(A_CTRL, 32'h0001_0002);
    bus_write(A_DATA, 32'h300);
    bus_write(A_DATA, 32'h301);
    wait_beats(5);
    checks++;
    if (got_data.size() != 5) begin errors++; $display("FAIL clr_count got %0d exp 5", got_data.size()); end
    for (int i = 0; i < 5 && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_d[i] || got_last[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL clr_beat%0d got d=%h l=%0b exp d=%h l=%0b", i, got_data[i], got_last[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_reset_streaming();
    logic [31:0] r;
    strm_out_ready = 1'b0;
    bus_write(A_CTRL, 32'h0001_0004);
    for (int i = 0; i < 3; i++) bus_write(A_DATA, 32'h500 + 32'(i));
    bus_read(A_STATUS, r);
    checks++;
    if (strm_out_valid !== 1'b1 || r !== 32'h0007_0002) begin
      errors++;
      $display("FAIL rst_pre got v=%0b st=%h exp v=1 st=00070002", strm_out_valid, r);
    end
    pulse_reset();
    @(negedge clk);
    checks++;
    if (strm_out_valid !== 1'b0 || strm_out_last !== 1'b0 || strm_out_data !== 32'h0) begin
      errors++;
      $display("FAIL rst_stream got v=%0b l=%0b d=%h exp 0 0 0", strm_out_valid, strm_out_last, strm_out_data);
    end
    checks++;
    if (dbg_state !== S_IDLE || bus_req_ready !== 1'b1 || bus_rsp_valid !== 1'b0 || bus_rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_bus got st=%0d rdy=%0b rv=%0b rd=%h exp 0 1 0 0", dbg_state, bus_req_ready, bus_rsp_valid, bus_rsp_rdata);
    end
    @(posedge clk); #1;
    bus_read(A_STATUS, r);
    checks++;
    if (r !== 32'h0000_0200) begin errors++; $display("FAIL rst_status got %h exp 00000200", r); end
    bus_read(A_CTRL, r);
    checks++;
    if (r !== 32'h0000_0080) begin errors++; $display("FAIL rst_ctrl got %h exp 00000080", r); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst            = 1'b1;
    bus_req_valid  = 1'b0;
    bus_req_write  = 1'b0;
    bus_req_addr   = '0;
    bus_req_wdata  = '0;
    strm_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    test_reset();
    test_latency();
    test_framing();
    test_eof();
    test_back_to_back();
    test_random_ready();
    test_fw_zero();
    test_clear();
    test_reset_streaming();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
